jfpjc_stream_sequencer: RTL

Frame-level output controller for the jfpjc compressor. On each frame start it emits the fixed JPEG header from the header EBR, taking bytes QUANT_OFFSET..QUANT_OFFSET+63 from the quantization-table EBR instead. It then forwards the compressor's entropy-coded bytes through a small FIFO and appends the EOI marker FF D9. It also arbitrates the single quantization-table EBR read port between itself and the compressor, so a complete .jpg byte stream leaves the chip with ready/valid handshaking.

---
 rtl/jfpjc_stream_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/jfpjc_stream_sequencer.sv
// Frame-level output controller: emits the JPEG header (quant table spliced in from
// its own EBR), forwards buffered entropy-coded bytes, then appends the EOI marker.
module jfpjc_stream_sequencer #(
  parameter int HEADER_LEN      = 328,
  parameter int QUANT_OFFSET    = 25,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       frame_start,
  input  logic       frame_end,
  input  logic       comp_valid,
  input  logic [7:0] comp_data,
  input  logic [5:0] comp_quant_raddr,
  input  logic       comp_quant_ren,
  output logic [5:0] quant_raddr,
  output logic       quant_ren,
  input  logic [7:0] quant_dout,
  output logic [8:0] header_raddr,
  output logic       header_ren,
  input  logic [7:0] header_dout,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       overflow
);

  typedef enum logic [2:0] {
    IDLE, HDR_FETCH, HDR_WAIT, HDR_OUT, DATA, EOI_FF, EOI_D9
  } state_t;

  localparam int         AW       = FIFO_DEPTH_LOG2;
  localparam int         DEPTH    = 1 << FIFO_DEPTH_LOG2;
  localparam logic [8:0] Q_LO     = 9'(QUANT_OFFSET);
  localparam logic [8:0] Q_HI     = 9'(QUANT_OFFSET + 64);
  localparam logic [8:0] IDX_LAST = 9'(HEADER_LEN - 1);

  state_t      state;
  logic [8:0]  idx;
  logic        end_pending;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  fifo_mem [DEPTH];

  logic       in_quant;
  logic       seq_quant;
  logic       fifo_empty;
  logic       fifo_full;
  logic       out_load;
  logic       pop;
  logic       bypass;
  logic       accept;
  logic       push;
  logic       drop;
  logic [7:0] fifo_head;

  // The compressor always wins the quant EBR; the sequencer only claims it in idle slots.
  always_comb begin
    in_quant     = (idx >= Q_LO) && (idx < Q_HI);
    seq_quant    = (state == HDR_FETCH) && in_quant && !comp_quant_ren;
    quant_ren    = seq_quant | comp_quant_ren;
    quant_raddr  = seq_quant ? 6'(idx - Q_LO) : comp_quant_raddr;
    header_ren   = (state == HDR_FETCH) && !in_quant;
    header_raddr = idx;

    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

    // An empty FIFO lets a fresh compressor byte fall straight into the output register.
    out_load = (state == DATA) && (!out_valid || out_ready);
    pop      = out_load && !fifo_empty;
    bypass   = out_load && fifo_empty && comp_valid;
    accept   = comp_valid && (state != IDLE);
    push     = accept && !bypass && (!fifo_full || pop);
    drop     = accept && !bypass && fifo_full && !pop;
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= comp_data;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      idx         <= '0;
      end_pending <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      busy        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (frame_end && (state != IDLE)) end_pending <= 1'b1;
      if (drop) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case (state)
        IDLE: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          if (frame_start) begin
            state <= HDR_FETCH;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        HDR_FETCH: begin
          if (!(in_quant && comp_quant_ren)) state <= HDR_WAIT;
        end
        HDR_WAIT: begin
          out_data  <= in_quant ? quant_dout : header_dout;
          out_valid <= 1'b1;
          state     <= HDR_OUT;
        end
        HDR_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= DATA;
            end else begin
              idx   <= idx + 1'b1;
              state <= HDR_FETCH;
            end
          end
        end
        DATA: begin
          if (pop) begin
            out_data  <= fifo_head;
            out_valid <= 1'b1;
          end else if (bypass) begin
            out_data  <= comp_data;
            out_valid <= 1'b1;
          end else if (out_load) begin
            out_valid <= 1'b0;
            // EOI only once every buffered byte has actually left the output register.
            if (end_pending && !out_valid) begin
              state     <= EOI_FF;
              out_valid <= 1'b1;
              out_data  <= 8'hFF;
            end
          end
        end
        EOI_FF: begin
          if (out_ready) begin
            out_data <= 8'hD9;
            state    <= EOI_D9;
          end
        end
        EOI_D9: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            state       <= IDLE;
            busy        <= 1'b0;
            end_pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
